// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction memory loader.
// Holds the FSM state encoding, default reset vector and header length.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    HDR   = 3'd0,
    DATA  = 3'd1,
    CHK   = 3'd2,
    FLUSH = 3'd3,
    DONE  = 3'd4,
    ERR   = 3'd5
  } state_e;

  localparam logic [31:0] IMEM_BASE = 32'hBFC00000;
  localparam int          LEN_BYTES = 4;

endpackage

// File: rtl/imem_loader.sv
// Boot loader: length-prefixed byte stream -> byte-wide IMEM writes.
// Ports: clk, rst (sync, high), start, in_valid/in_data/in_ready stream,
//   we/waddr/wdata RAM write, cpu_hold, done, err status levels.
// Optional: IMEM_LOADER_CHECKSUM_EN adds a trailing mod-256 sum byte.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int          IMEM_BYTES = 4096,
  parameter logic [31:0] BASE_ADDR  = IMEM_BASE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        we,
  output logic [31:0] waddr,
  output logic [7:0]  wdata,
  output logic        cpu_hold,
  output logic        done,
  output logic        err
);

  localparam int CW = $clog2(IMEM_BYTES) + 1;
  localparam logic [CW-1:0] HDR_LAST = CW'(LEN_BYTES - 1);

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_e PAY_NEXT = CHK;
`else
  localparam state_e PAY_NEXT = FLUSH;
`endif

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [31:0]     len_q, len_d;
  logic            we_q, we_d;
  logic [31:0]     waddr_q, waddr_d;
  logic [7:0]      wdata_q, wdata_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]      sum_q, sum_d;
`endif

  logic            acc;
  logic [31:0]     len_full;
  logic [CW-1:0]   cnt_inc;

  assign in_ready = (state_q == HDR) |
                    (state_q == DATA) |
                    (state_q == CHK);
  assign acc      = in_valid & in_ready;
  // Little-endian: bytes shift in from the top, first ends in [7:0].
  assign len_full = {in_data, len_q[31:8]};
  assign cnt_inc  = cnt_q + 1'b1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    sum_d   = sum_q;
`endif
    unique case (state_q)
      HDR: begin
        if (acc) begin
          len_d = len_full;
          cnt_d = cnt_inc;
          if (cnt_q == HDR_LAST) begin
            cnt_d = '0;
            if (len_full > 32'(IMEM_BYTES))
              state_d = ERR;
            else if (len_full == 32'd0)
              state_d = PAY_NEXT;
            else
              state_d = DATA;
          end
        end
      end
      DATA: begin
        if (acc) begin
          we_d    = 1'b1;
          waddr_d = BASE_ADDR + 32'(cnt_q);
          wdata_d = in_data;
          cnt_d   = cnt_inc;
`ifdef IMEM_LOADER_CHECKSUM_EN
          sum_d   = sum_q + in_data;
`endif
          // len fits CW bits: oversize was rejected in HDR.
          if (cnt_inc == len_q[CW-1:0])
            state_d = PAY_NEXT;
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHK: begin
        if (acc)
          state_d = (in_data == sum_q) ? FLUSH : ERR;
      end
`endif
      FLUSH: state_d = DONE;
      DONE, ERR: begin
        if (start) begin
          state_d = HDR;
          cnt_d   = '0;
          len_d   = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          sum_d   = '0;
`endif
        end
      end
      default: state_d = HDR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= HDR;
      cnt_q   <= '0;
      len_q   <= '0;
      we_q    <= 1'b0;
      waddr_q <= BASE_ADDR;
      wdata_q <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q   <= sum_d;
`endif
    end
  end

  assign we       = we_q;
  assign waddr    = waddr_q;
  assign wdata    = wdata_q;
  assign done     = (state_q == DONE);
  assign err      = (state_q == ERR);
  assign cpu_hold = (state_q != DONE);

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time writer for the instruction memory.
- Accepts a length-prefixed byte stream (valid/ready) from a host link such as a UART receiver.
- Writes each payload byte into the byte-wide instruction RAM, starting at the reset vector 0xBFC00000.
- Holds the CPU in reset until the image is fully and correctly loaded.

Parameters:
- IMEM_BYTES, 4096: capacity of the instruction RAM in bytes; the largest legal payload.
- BASE_ADDR, 32'hBFC00000: address written for payload byte 0.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- start  input  1  one-cycle pulse; restarts loading from DONE or ERR
- in_valid  input  1  stream byte valid
- in_data  input  8  stream byte
- in_ready  output  1  loader accepts the byte this cycle
- we  output  1  instruction RAM byte write enable
- waddr  output  32  instruction RAM byte address
- wdata  output  8  instruction RAM write data
- cpu_hold  output  1  holds the CPU in reset while high
- done  output  1  image loaded, level
- err  output  1  load failed, level

Behaviour:
- Reset values: state=HDR, in_ready=1, we=0, waddr=BASE_ADDR, wdata=0, cpu_hold=1, done=0, err=0, byte counter=0, length=0.
- A byte is accepted only when in_valid && in_ready on a rising clk edge.
- in_ready is 1 in HDR, DATA and CHK; 0 in FLUSH, DONE and ERR.
- HDR state:
  - Collects 4 bytes as a little-endian 32-bit length L; the first byte is L[7:0].
  - After the 4th byte: if L > IMEM_BYTES, go to ERR.
  - If L == 0, go to CHK when CHECKSUM_EN is defined, otherwise to FLUSH.
  - Otherwise go to DATA.
- DATA state:
  - Byte k (k = 0..L-1) accepted in cycle t produces we=1, waddr=BASE_ADDR+k, wdata=byte in cycle t+1. Registered, latency 1.
  - we is otherwise 0; waddr/wdata hold their last values.
  - Back-to-back acceptance gives one write per cycle.
  - After byte L-1: go to CHK when CHECKSUM_EN is defined, otherwise to FLUSH.
  - Offset arithmetic is unsigned with width clog2(IMEM_BYTES)+1. No wrap can occur, because L <= IMEM_BYTES is checked in HDR.
- FLUSH state: lasts one cycle so the final write completes, then goes to DONE.
  - Final byte accepted in cycle t: we=1 at t+1, done=1 and cpu_hold=0 from t+2.
- DONE state: done=1, cpu_hold=0. Stays until start or rst.
- ERR state: err=1, cpu_hold=1, done=0. Stays until start or rst.
- start:
  - Honoured only in DONE or ERR.
  - Next cycle: state=HDR, cpu_hold=1, done=0, err=0, counters cleared.
  - Ignored in HDR, DATA, CHK and FLUSH.
- rst in any state, including mid-DATA: returns to the reset values next cycle. No pending write is issued. RAM contents already written are left untouched.
- in_valid with no handshake does not change state. Bytes presented while in_ready=0 are not consumed.

Optional Feature:
- Macro name: IMEM_LOADER_CHECKSUM_EN.
- Defined:
  - An 8-bit running sum (mod 256) of the payload bytes is kept; it is cleared on entry to HDR.
  - CHK state accepts exactly one byte. If it equals the sum, go to FLUSH; otherwise go to ERR.
  - A mismatch leaves the written data in RAM, but cpu_hold stays 1.
- Undefined: no CHK state and no sum register; the byte after the payload is not consumed.

Decomposition:
- Package imem_loader_pkg holds:
  - state enum: HDR, DATA, CHK, FLUSH, DONE, ERR
  - IMEM_BASE = 32'hBFC00000 (default for BASE_ADDR)
  - LEN_BYTES = 4
- No sub-module: a single FSM with counter, length register and optional sum register.

Test Plan:
- Basic load: stream 04 00 00 00 then 13 05 A0 00, in_valid held high -> 4 writes on consecutive cycles to BFC00000..BFC00003 with data 13,05,A0,00; done=1 and cpu_hold=0 two cycles after the last byte is accepted.
- Throttled stream: same image with in_valid toggled every other cycle -> identical writes, each exactly one cycle after its handshake; no write while in_valid=0.
- Oversize: header 01 10 00 00 (L=4097) -> ERR after the 4th byte, in_ready=0, no we pulses; a start pulse then returns to HDR with err=0.
- Zero length: header 00 00 00 00 (without the macro) -> no writes, done=1 two cycles after the 4th byte.
- Reset mid-load: L=8, rst asserted after 3 data bytes -> outputs at reset values next cycle; reloading an 8-byte image then writes from BFC00000.
- With IMEM_LOADER_CHECKSUM_EN: payload 01 02 03 followed by checksum 06 -> done=1; the same payload followed by 07 -> err=1, cpu_hold=1, and all 3 writes still occurred.
